// File: rtl/mem_io_responder_if.sv
// -----------------------------------------------------------------------------
// mem_io_responder_if
// Bundles the CPU byte bus and the UART harness handshakes seen by
// mem_io_responder.
//
// Signals:
//   mem_a[31:0]     bus address (only bits 17:0 are decoded)
//   mem_wr          1 = write, 0 = read
//   mem_dout[7:0]   write data from the CPU
//   mem_din[7:0]    registered read data to the CPU
//   io_buffer_full  TX FIFO nearly full (one cycle of margin for the core)
//   tx_valid        TX FIFO non-empty
//   tx_data[7:0]    TX FIFO head byte
//   tx_ready        UART accepts the head byte
//   rx_valid        UART has a received byte
//   rx_data[7:0]    the received byte
//   rx_pop          received byte consumed this cycle
//   prog_stop       sticky program-stop flag
//
// Modports:
//   master - CPU core plus UART harness side (drives address/data/handshakes)
//   slave  - the responder
// -----------------------------------------------------------------------------
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        prog_stop;

    modport master (
        output mem_a,
        output mem_wr,
        output mem_dout,
        output tx_ready,
        output rx_valid,
        output rx_data,
        input  mem_din,
        input  io_buffer_full,
        input  tx_valid,
        input  tx_data,
        input  rx_pop,
        input  prog_stop
    );

    modport slave (
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        output mem_din,
        output io_buffer_full,
        output tx_valid,
        output tx_data,
        output rx_pop,
        output prog_stop
    );
endinterface

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Memory-side responder for the CPU byte bus. Every clock cycle is a bus
// transaction. Address a = mem_a[17:0] decodes to:
//   RAM  : a[17:16] != 2'b11 and a < 2**ADDR_WIDTH (byte RAM, not reset)
//   IO   : a[17:16] == 2'b11, low 3 bits decoded
//            +0 read : UART RX byte (pops it), 0x00 if none pending
//            +0 write: push byte into TX FIFO (0x00 ignored)
//            +4 write: push 0x00 end marker into TX FIFO, set prog_stop
//            +4 read : snapshot cycle counter, return byte 0
//            +5..+7  : snapshot bytes 1..3 (little-endian)
//   Hole : everything else (reads 0x00, writes dropped)
//
// Parameters:
//   ADDR_WIDTH    (17) RAM holds 2**ADDR_WIDTH bytes (at most 18)
//   TX_DEPTH_LOG2 (3)  TX FIFO holds 2**TX_DEPTH_LOG2 bytes
//
// Ports:
//   clk_in   single clock
//   rst_n_in asynchronous active-low reset
//   bus      mem_io_responder_if.slave (bus, UART TX/RX handshakes, prog_stop)
//
// Build option:
//   MEM_IO_CYCLE_COUNTER_EN - when defined, the free-running 32-bit cycle
//   counter and its read snapshot exist; otherwise reads of +4..+7 return
//   0x00 (the +4 write behaviour is unaffected).
// -----------------------------------------------------------------------------
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_DEPTH_LOG2 = 3
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    mem_io_responder_if.slave  bus
);

    localparam int RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int DEPTH     = 1 << TX_DEPTH_LOG2;
    localparam int CW        = TX_DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]            DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]            CNT_ONE = CW'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] PTR_ONE = TX_DEPTH_LOG2'(1);

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [17:0]           addr_s;
    logic                  is_io_s;
    logic                  in_ram_range_s;
    logic                  is_ram_s;
    logic [2:0]            io_off_s;
    logic [ADDR_WIDTH-1:0] ram_idx_s;
    logic                  io_rd0_s;
    logic                  io_rd4_s;
    logic                  unused_addr_s;

    assign addr_s         = bus.mem_a[17:0];
    assign is_io_s        = (addr_s[17:16] == 2'b11);
    // Range check done in 32 bits so any ADDR_WIDTH up to 18 works.
    assign in_ram_range_s = ((32'(addr_s) >> ADDR_WIDTH) == 32'd0);
    assign is_ram_s       = !is_io_s && in_ram_range_s;
    assign io_off_s       = addr_s[2:0];
    assign ram_idx_s      = addr_s[ADDR_WIDTH-1:0];
    assign io_rd0_s       = is_io_s && !bus.mem_wr && (io_off_s == 3'd0);
    assign io_rd4_s       = is_io_s && !bus.mem_wr && (io_off_s == 3'd4);
    assign unused_addr_s  = ^bus.mem_a[31:18];

    // ---------------------------------------------------------------------
    // Byte RAM (contents survive reset)
    // ---------------------------------------------------------------------
    logic [7:0] ram_q [RAM_BYTES];

    // RAM write port: data committed at the sampling edge.
    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && is_ram_s) begin
            ram_q[ram_idx_s] <= bus.mem_dout;
        end
    end

    // ---------------------------------------------------------------------
    // Cycle counter and read snapshot
    // ---------------------------------------------------------------------
`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] snap_q;
    logic [31:0] snap_d;

    // Counter free-runs (wrapping); snapshot reloads only on a +4 read so
    // +5..+7 return a coherent 32-bit value.
    always_comb begin
        cnt_d  = cnt_q + 32'd1;
        snap_d = snap_q;
        if (io_rd4_s) begin
            snap_d = cnt_q;
        end else begin
            snap_d = snap_q;
        end
    end

    // Counter and snapshot registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= 32'd0;
            snap_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end
`else
    logic unused_rd4_s;
    assign unused_rd4_s = io_rd4_s;
`endif

    // ---------------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------------
    logic [7:0]               tx_buf_q [DEPTH];
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_d;
    logic [TX_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [TX_DEPTH_LOG2-1:0] rd_ptr_d;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic                     tx_push_req_s;
    logic [7:0]               tx_push_data_s;
    logic                     tx_push_s;
    logic                     tx_pop_s;
    logic                     stop_set_s;

    // Decode which IO writes produce a FIFO push and with what byte.
    always_comb begin
        tx_push_req_s  = 1'b0;
        tx_push_data_s = 8'h00;
        stop_set_s     = 1'b0;
        if (bus.mem_wr && is_io_s) begin
            case (io_off_s)
                3'd0: begin
                    // A zero byte on the data port is not output.
                    tx_push_req_s  = (bus.mem_dout != 8'h00);
                    tx_push_data_s = bus.mem_dout;
                end
                3'd4: begin
                    tx_push_req_s  = 1'b1;
                    tx_push_data_s = 8'h00;
                    stop_set_s     = 1'b1;
                end
                default: begin
                    tx_push_req_s  = 1'b0;
                    tx_push_data_s = 8'h00;
                    stop_set_s     = 1'b0;
                end
            endcase
        end else begin
            tx_push_req_s  = 1'b0;
            tx_push_data_s = 8'h00;
            stop_set_s     = 1'b0;
        end
    end

    assign tx_pop_s  = (count_q != {CW{1'b0}}) && bus.tx_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign tx_push_s = tx_push_req_s && ((count_q < DEPTH_C) || tx_pop_s);

    // FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (tx_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (tx_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care once pointers reset.
    always_ff @(posedge clk_in) begin
        if (tx_push_s) begin
            tx_buf_q[wr_ptr_q] <= tx_push_data_s;
        end
    end

    // FIFO pointer and count registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= {TX_DEPTH_LOG2{1'b0}};
            rd_ptr_q <= {TX_DEPTH_LOG2{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Read data mux and sticky stop flag
    // ---------------------------------------------------------------------
    logic [7:0] din_q;
    logic [7:0] din_d;
    logic       stop_q;
    logic       stop_d;

    // Select the byte returned one cycle after the address is sampled.
    always_comb begin
        din_d = 8'h00;
        if (bus.mem_wr) begin
            din_d = 8'h00;
        end else if (is_ram_s) begin
            din_d = ram_q[ram_idx_s];
        end else if (is_io_s) begin
            case (io_off_s)
                3'd0:    din_d = bus.rx_valid ? bus.rx_data : 8'h00;
`ifdef MEM_IO_CYCLE_COUNTER_EN
                3'd4:    din_d = cnt_q[7:0];
                3'd5:    din_d = snap_q[15:8];
                3'd6:    din_d = snap_q[23:16];
                3'd7:    din_d = snap_q[31:24];
`endif
                default: din_d = 8'h00;
            endcase
        end else begin
            din_d = 8'h00;
        end
        stop_d = stop_q | stop_set_s;
    end

    // Read data and stop flag registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            din_q  <= 8'h00;
            stop_q <= 1'b0;
        end else begin
            din_q  <= din_d;
            stop_q <= stop_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.mem_din        = din_q;
    assign bus.prog_stop      = stop_q;
    assign bus.tx_valid       = (count_q != {CW{1'b0}});
    assign bus.tx_data        = tx_buf_q[rd_ptr_q];
    assign bus.io_buffer_full = (count_q >= (DEPTH_C - CNT_ONE));
    // The RX handshake must be combinational so the byte is consumed in the
    // same cycle as the read; gated so reset never pops a byte.
    assign bus.rx_pop         = rst_n_in && bus.rx_valid && io_rd0_s;

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. Services every bus cycle issued by the CPU core: a 128 KB byte RAM region, plus the memory-mapped I/O page at `mem_a[17:16]==2'b11`. The I/O page holds a UART transmit FIFO that drives `io_buffer_full` back to the core, a UART receive byte port, a free-running cycle counter and the program-stop flag. Sits between the `cpu` top and the board/UART harness.

## Interface
- `ADDR_WIDTH`, default 17: RAM size is 2^ADDR_WIDTH bytes.
- `TX_DEPTH_LOG2`, default 3: TX FIFO depth is 2^TX_DEPTH_LOG2 entries (DEPTH).

Ports:
- `clk_in`, input, 1: the single clock.
- `rst_n_in`, input, 1: asynchronous active-low reset.
- `mem_a`, input, 32: bus address. Only bits 17:0 are decoded.
- `mem_wr`, input, 1: 1 = write, 0 = read.
- `mem_dout`, input, 8: write data from the CPU.
- `mem_din`, output, 8: registered read data to the CPU.
- `io_buffer_full`, output, 1: TX FIFO nearly full.
- `tx_valid`, output, 1: TX FIFO non-empty.
- `tx_data`, output, 8: TX FIFO head byte.
- `tx_ready`, input, 1: UART accepts the head byte.
- `rx_valid`, input, 1: UART has a received byte.
- `rx_data`, input, 8: the received byte.
- `rx_pop`, output, 1: the received byte is consumed this cycle.
- `prog_stop`, output, 1: sticky; the program has written 0x30004.

## Operation
- Every clock cycle is a bus transaction. There is no valid strobe.
- **Address decode** on `a = mem_a[17:0]`:
  - RAM: `a[17:16] != 2'b11` and `a < 2^ADDR_WIDTH`.
  - IO: `a[17:16] == 2'b11`; only the low 3 bits are decoded.
  - Hole: all other addresses. Reads return 0x00; writes are dropped.
- **RAM write:** the byte is stored at the clock edge. RAM contents are not cleared by reset.
- **RAM read:** returns the byte at address `a`.
- **IO 0x30000 read:**
  - If `rx_valid`: return `rx_data` and assert `rx_pop` in the same cycle. `rx_pop = rx_valid` AND read decode, combinational, forced to 0 during reset.
  - If no byte is pending: return 0x00.
- **IO 0x30000 write:**
  - Data 0x00 is ignored.
  - Otherwise the byte is pushed into the TX FIFO.
- **IO 0x30004 write:** push 0x00 into the TX FIFO (the end-of-output marker) and set `prog_stop`. `prog_stop` clears only on reset.
- **IO 0x30004–0x30007 reads:**
  - Reading 0x30004 captures a snapshot of the 32-bit cycle counter and returns snapshot byte 0.
  - 0x30005, 0x30006 and 0x30007 return snapshot bytes 1, 2 and 3 without re-capturing.
  - Byte order is little-endian.
- **Cycle counter:** 32 bits, increments every cycle after reset, wraps 0xFFFFFFFF→0.
- **TX FIFO:**
  - Circular buffer with a `(TX_DEPTH_LOG2+1)`-bit count.
  - Pop on `tx_valid && tx_ready`.
  - A push is accepted if `count < DEPTH`, or if a pop occurs in the same cycle. Otherwise the byte is dropped.
  - Simultaneous push and pop leaves the count unchanged.
- **io_buffer_full** = `count >= DEPTH-1`, combinational from the registered count. This gives the core one cycle of margin.
- Writes to unused IO offsets (0x30001–0x30003, 0x30005–0x30007) are ignored; reads of 0x30001–0x30003 return 0x00.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and `mem_din` is valid after edge N, through edge N+1.
- Write latency is 0 wait cycles: data is committed at the sampling edge, and a read of the same address in the next cycle returns the new byte.
- The TX FIFO head (`tx_data`) is updated the cycle after a push into an empty FIFO.
- Reset values:
  - `mem_din` = 0x00
  - `tx_valid` = 0
  - `io_buffer_full` = 0
  - `prog_stop` = 0
  - `rx_pop` = 0
  - cycle counter = 0
  - snapshot = 0
  - FIFO pointers and count = 0
- Reset asserted mid-operation:
  - All of the above are cleared immediately (asynchronous reset).
  - An in-flight read returns 0x00.
  - FIFO contents are discarded.

## Configuration
- `MEM_IO_CYCLE_COUNTER_EN`:
  - Defined: the cycle counter and snapshot registers exist as described.
  - Undefined: no counter or snapshot flops; reads of 0x30004–0x30007 return 0x00. 0x30004 write behaviour is unchanged.

## Test plan
- RAM round trip: write 0xA5 to 0x00010, read 0x00010 in the next cycle → `mem_din` = 0xA5 one cycle later. Read 0x1FFFF after writing 0x3C → 0x3C.
- UART output: write 'H' (0x48), then 0x00, then 'i' (0x69) to 0x30000 with `tx_ready` = 0 → FIFO count = 2. Release `tx_ready` → `tx_data` sequence 0x48, 0x69, then `tx_valid` = 0.
- Backpressure: DEPTH = 8, `tx_ready` = 0, write 7 bytes → `io_buffer_full` = 1 after the 7th. The 8th write is accepted; a 9th write is dropped. At count = 8, a push with a simultaneous pop is accepted.
- Input: `rx_valid` = 1, `rx_data` = 0x31, read 0x30000 → `rx_pop` = 1 in the same cycle and `mem_din` = 0x31 next cycle. Read with `rx_valid` = 0 → 0x00 and `rx_pop` = 0.
- Counter: after 1000 cycles from reset release, read 0x30004–0x30007 → the four bytes form ~1000 (e.g. 0xE8, 0x03, 0x00, 0x00). With the macro undefined → all 0x00.
- Stop and reset: write 0x30004 → `prog_stop` = 1 and 0x00 is emitted on `tx_data`. Assert `rst_n_in` low mid-read → `mem_din`, `prog_stop` and `tx_valid` are all 0 immediately.
